// File: rtl/rv32_regfile_writeback_if.sv
// Register-file write-side bundle: ALU and load result producers, issue tap, RF write port.
// The slave modport is the writeback block; the master modport is its surrounding pipeline.
interface rv32_regfile_writeback_if #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [REG_ADDR_WIDTH-1:0] alu_wa;
  logic [XPR_LEN-1:0]        alu_wd;

  logic                      ld_valid;
  logic                      ld_ready;
  logic [REG_ADDR_WIDTH-1:0] ld_wa;
  logic [XPR_LEN-1:0]        ld_wd;

  logic                      issue_valid;
  logic [REG_ADDR_WIDTH-1:0] issue_wa;

  logic                      wen;
  logic [REG_ADDR_WIDTH-1:0] wa;
  logic [XPR_LEN-1:0]        wd;
  logic [31:0]               pending;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output ld_valid, ld_wa, ld_wd,
    output issue_valid, issue_wa,
    input  alu_ready, ld_ready,
    input  wen, wa, wd, pending
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  ld_valid, ld_wa, ld_wd,
    input  issue_valid, issue_wa,
    output alu_ready, ld_ready,
    output wen, wa, wd, pending
  );
endinterface

// File: rtl/rv32_regfile_writeback.sv
// Merges ALU (1-cycle) and buffered load results (>=2 cycles) onto one registered RF write port.
// Full load queue drains first and stalls both producers; pending scoreboard tracks outstanding writes.
module rv32_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module rv32_regfile_writeback #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LQ_DEPTH       = 4
) (
  input logic                    clk,
  input logic                    rst,
  rv32_regfile_writeback_if.slave bus
);
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] wa;
    logic [XPR_LEN-1:0]        wd;
  } wr_t;

  wr_t   alu_req;
  wr_t   ld_req;
  wr_t   lq_head;
  wr_t   sel;
  logic  lq_full;
  logic  lq_empty;
  logic  lq_push;
  logic  lq_pop;
  logic  take_alu;
  logic  any_sel;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_nxt;

  assign alu_req.wa = bus.alu_wa;
  assign alu_req.wd = bus.alu_wd;
  assign ld_req.wa  = bus.ld_wa;
  assign ld_req.wd  = bus.ld_wd;

  assign bus.ld_ready  = !lq_full;
  assign bus.alu_ready = !lq_full;
  assign lq_push       = bus.ld_valid && !lq_full;

  rv32_wb_fifo #(
    .W     ($bits(wr_t)),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk      (clk),
    .rst      (rst),
    .push     (lq_push),
    .push_dat (ld_req),
    .pop      (lq_pop),
    .head_dat (lq_head),
    .full     (lq_full),
    .empty    (lq_empty)
  );

  // A full queue always takes the slot so loads cannot be starved by a busy ALU.
  always_comb begin
    take_alu = bus.alu_valid && !lq_full;
    lq_pop   = lq_full || (!bus.alu_valid && !lq_empty);
    any_sel  = take_alu || lq_pop;
    sel      = take_alu ? alu_req : lq_head;
  end

  always_comb begin
    set_mask    = (bus.issue_valid && bus.issue_wa != '0) ? (32'(1) << bus.issue_wa) : '0;
    clr_mask    = bus.wen ? (32'(1) << bus.wa) : '0;
    pending_nxt = (bus.pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wen     <= 1'b0;
      bus.wa      <= '0;
      bus.wd      <= '0;
      bus.pending <= '0;
    end else begin
      bus.wen     <= any_sel && (sel.wa != '0);
      bus.pending <= pending_nxt;
      if (any_sel) begin
        bus.wa <= sel.wa;
        bus.wd <= sel.wd;
      end
    end
  end
endmodule

// File: tb/tb_rv32_regfile_writeback.sv
// Directed bench for rv32_regfile_writeback: each task drives one scenario and checks inline.
module tb_rv32_regfile_writeback;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  rv32_regfile_writeback_if #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) bif ();

  rv32_regfile_writeback #(
    .XPR_LEN        (32),
    .REG_ADDR_WIDTH (5),
    .LQ_DEPTH       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.alu_valid   = 1'b0;
    bif.alu_wa      = '0;
    bif.alu_wd      = '0;
    bif.ld_valid    = 1'b0;
    bif.ld_wa       = '0;
    bif.ld_wd       = '0;
    bif.issue_valid = 1'b0;
    bif.issue_wa    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    n_cmp++;
    if ({bif.wen, bif.wa, bif.wd} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_port: got %0b/%0d/%h want 0/0/0", bif.wen, bif.wa, bif.wd);
    end
    n_cmp++;
    if (bif.pending !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pending: got %h want 0", bif.pending);
    end
    n_cmp++;
    if ({bif.alu_ready, bif.ld_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 11", {bif.alu_ready, bif.ld_ready});
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (bif.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_wen: got %b want 0", bif.wen);
    end
  endtask

  task automatic test_alu_single();
    bif.issue_valid = 1'b1;
    bif.issue_wa    = 5'd5;
    step();
    bif.issue_valid = 1'b0;
    n_cmp++;
    if (bif.pending !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL alu_pending_set: got %h want 00000020", bif.pending);
    end
    bif.alu_valid = 1'b1;
    bif.alu_wa    = 5'd5;
    bif.alu_wd    = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (bif.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready: got %b want 1", bif.alu_ready);
    end
    step();
    bif.alu_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.wa, bif.wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef", bif.wen, bif.wa, bif.wd);
    end
    n_cmp++;
    if (bif.pending !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL alu_pending_hold: got %h want 00000020", bif.pending);
    end
    step();
    n_cmp++;
    if ({bif.wen, bif.pending} !== 33'd0) begin
      n_fail++;
      $display("FAIL alu_pending_clr: got wen=%b pending=%h want 0/0", bif.wen, bif.pending);
    end
  endtask

  task automatic test_load_order();
    bif.ld_valid = 1'b1;
    bif.ld_wa    = 5'd1;
    bif.ld_wd    = 32'h11;
    step();
    n_cmp++;
    if (bif.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_first_cycle_wen: got %b want 0", bif.wen);
    end
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        bif.ld_wa = 5'(k + 2);
        bif.ld_wd = 32'(8'h22 + 8'h11 * k);
      end else begin
        bif.ld_valid = 1'b0;
      end
      step();
      n_cmp++;
      if ({bif.wen, bif.wa, bif.wd} !== {1'b1, 5'(k + 1), 32'(8'h11 * (k + 1))}) begin
        n_fail++;
        $display("FAIL ld_order_%0d: got %b/%0d/%h want 1/%0d/%h",
                 k, bif.wen, bif.wa, bif.wd, k + 1, 8'h11 * (k + 1));
      end
    end
    step();
    n_cmp++;
    if (bif.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_drained_wen: got %b want 0", bif.wen);
    end
  endtask

  task automatic test_full_priority();
    bif.alu_valid = 1'b1;
    bif.alu_wa    = 5'd10;
    bif.ld_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bif.alu_wd = 32'(32'hA0 + k);
      bif.ld_wa  = 5'(11 + k);
      bif.ld_wd  = 32'(32'h101 + k);
      #1;
      n_cmp++;
      if ({bif.alu_ready, bif.ld_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL full_ready_%0d: got %b want 11", k, {bif.alu_ready, bif.ld_ready});
      end
      step();
      n_cmp++;
      if ({bif.wen, bif.wa, bif.wd} !== {1'b1, 5'd10, 32'(32'hA0 + k)}) begin
        n_fail++;
        $display("FAIL full_alu_wins_%0d: got %b/%0d/%h want 1/10/%h",
                 k, bif.wen, bif.wa, bif.wd, 32'hA0 + k);
      end
    end
    bif.ld_valid = 1'b0;
    bif.alu_wd   = 32'hAF;
    #1;
    n_cmp++;
    if ({bif.alu_ready, bif.ld_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_stall: got %b want 00", {bif.alu_ready, bif.ld_ready});
    end
    step();
    n_cmp++;
    if ({bif.wen, bif.wa, bif.wd} !== {1'b1, 5'd11, 32'h101}) begin
      n_fail++;
      $display("FAIL full_drain_head: got %b/%0d/%h want 1/11/101", bif.wen, bif.wa, bif.wd);
    end
    n_cmp++;
    if ({bif.alu_ready, bif.ld_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_unstall: got %b want 11", {bif.alu_ready, bif.ld_ready});
    end
    bif.alu_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      n_cmp++;
      if ({bif.wen, bif.wa, bif.wd} !== {1'b1, 5'(11 + k), 32'(32'h101 + k)}) begin
        n_fail++;
        $display("FAIL full_drain_%0d: got %b/%0d/%h want 1/%0d/%h",
                 k, bif.wen, bif.wa, bif.wd, 11 + k, 32'h101 + k);
      end
    end
    step();
    n_cmp++;
    if (bif.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty_wen: got %b want 0", bif.wen);
    end
  endtask

  task automatic test_x0();
    bif.alu_valid   = 1'b1;
    bif.alu_wa      = 5'd0;
    bif.alu_wd      = 32'hFFFF_FFFF;
    bif.issue_valid = 1'b1;
    bif.issue_wa    = 5'd0;
    #1;
    n_cmp++;
    if (bif.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_alu_ready: got %b want 1", bif.alu_ready);
    end
    step();
    bif.alu_valid   = 1'b0;
    bif.issue_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.pending} !== 33'd0) begin
      n_fail++;
      $display("FAIL x0_alu: got wen=%b pending=%h want 0/0", bif.wen, bif.pending);
    end
    bif.ld_valid = 1'b1;
    bif.ld_wa    = 5'd0;
    bif.ld_wd    = 32'h55;
    step();
    bif.ld_valid = 1'b0;
    step();
    n_cmp++;
    if (bif.wen !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_load: got wen=%b want 0", bif.wen);
    end
  endtask

  task automatic test_collision();
    bif.issue_valid = 1'b1;
    bif.issue_wa    = 5'd7;
    step();
    bif.issue_valid = 1'b0;
    bif.alu_valid   = 1'b1;
    bif.alu_wa      = 5'd7;
    bif.alu_wd      = 32'h77;
    step();
    bif.alu_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.wa, bif.pending} !== {1'b1, 5'd7, 32'h80}) begin
      n_fail++;
      $display("FAIL coll_first_write: got %b/%0d/%h want 1/7/00000080", bif.wen, bif.wa, bif.pending);
    end
    bif.issue_valid = 1'b1;
    bif.issue_wa    = 5'd7;
    step();
    bif.issue_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.pending} !== {1'b0, 32'h80}) begin
      n_fail++;
      $display("FAIL coll_set_wins: got wen=%b pending=%h want 0/00000080", bif.wen, bif.pending);
    end
    bif.alu_valid = 1'b1;
    bif.alu_wd    = 32'h78;
    step();
    bif.alu_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.wd} !== {1'b1, 32'h78}) begin
      n_fail++;
      $display("FAIL coll_second_write: got %b/%h want 1/78", bif.wen, bif.wd);
    end
    step();
    n_cmp++;
    if (bif.pending !== 32'd0) begin
      n_fail++;
      $display("FAIL coll_clear: got %h want 0", bif.pending);
    end
  endtask

  task automatic test_reset_mid();
    bif.alu_valid   = 1'b1;
    bif.alu_wa      = 5'd9;
    bif.alu_wd      = 32'h99;
    bif.ld_valid    = 1'b1;
    bif.ld_wa       = 5'd20;
    bif.ld_wd       = 32'h2020;
    bif.issue_valid = 1'b1;
    bif.issue_wa    = 5'd20;
    step();
    bif.issue_valid = 1'b0;
    bif.ld_wa       = 5'd21;
    bif.ld_wd       = 32'h2121;
    step();
    bif.ld_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.wa, bif.pending} !== {1'b1, 5'd9, 32'h0010_0000}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got %b/%0d/%h want 1/9/00100000", bif.wen, bif.wa, bif.pending);
    end
    #2;
    rst = 1'b1;
    #1;
    bif.alu_valid = 1'b0;
    n_cmp++;
    if ({bif.wen, bif.wa, bif.wd, bif.pending, bif.ld_ready} !== {38'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_async: got wen=%b wa=%0d wd=%h pending=%h ld_ready=%b want 0/0/0/0/1",
               bif.wen, bif.wa, bif.wd, bif.pending, bif.ld_ready);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bif.wen !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale_%0d: got wen=%b wa=%0d want wen 0", k, bif.wen, bif.wa);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_alu_single();
    test_load_order();
    test_full_priority();
    test_x0();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32_regfile_writeback.md
Name: rv32_regfile_writeback

Overview:
Write-side front end for the 32-entry RV32 integer register file. It merges two result producers onto the single register-file write port (wen/wa/wd):
- the single-cycle ALU path;
- a variable-latency load path, which is buffered in a small FIFO.
It also keeps a pending-write scoreboard, so issue logic can stall on registers that have an outstanding write.

Parameters:
- XPR_LEN, 32, data width of one register.
- REG_ADDR_WIDTH, 5, register index width.
- LQ_DEPTH, 4, load-result FIFO depth in entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_wa  in  REG_ADDR_WIDTH  ALU destination register.
- alu_wd  in  XPR_LEN  ALU result data.
- ld_valid  in  1  load result available.
- ld_ready  out  1  load FIFO can accept.
- ld_wa  in  REG_ADDR_WIDTH  load destination register.
- ld_wd  in  XPR_LEN  load data.
- issue_valid  in  1  an instruction with a destination register is issuing.
- issue_wa  in  REG_ADDR_WIDTH  destination of the issuing instruction.
- wen  out  1  register-file write enable (registered).
- wa  out  REG_ADDR_WIDTH  register-file write address (registered).
- wd  out  XPR_LEN  register-file write data (registered).
- pending  out  32  bit i = 1 while a write to register i is outstanding.

Behaviour:
Reset
- While rst is high: wen=0, wa=0, wd=0, pending=0, FIFO emptied (count=0, pointers=0).
- Reset asserted mid-operation discards all buffered load results and pending bits.

Load FIFO
- ld_ready = (count != LQ_DEPTH), combinational from state only.
- Push on ld_valid && ld_ready; entries pushed in order, pointers wrap modulo LQ_DEPTH.
- A push and a pop in the same cycle leave count unchanged.

Arbitration (one write slot per cycle)
- Slot select priority:
  1. FIFO full: pop FIFO head; alu_ready=0.
  2. Otherwise, alu_valid: take ALU (alu_ready=1); FIFO holds.
  3. Otherwise, FIFO non-empty: pop FIFO head.
  4. Otherwise: no write; wen=0 next cycle.
- alu_ready = (count != LQ_DEPTH). alu_ready may be high while alu_valid is low.
- ALU latency: accepted at edge N → wen/wa/wd valid during cycle N+1.
- Load latency: every load passes through the FIFO; there is no bypass. Minimum latency: pushed at edge N, popped at edge N+1, wen high during cycle N+2.

x0 writes
- A selected write with address 0 is consumed normally (handshake or pop) but wen stays 0 that cycle.

Scoreboard
- Set pending[issue_wa] at an edge when issue_valid && issue_wa != 0.
- Clear pending[wa] at the edge ending a cycle in which wen=1.
- Set and clear of the same index on the same edge: set wins.
- pending[0] is hard-wired 0.
- Issuing to an already-pending register leaves the bit set; the next write clears it. Issue logic must not issue a second writer to a pending register.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with a FIFO holding 2 entries → wen=0, pending=0, ld_ready=1 immediately, no later write of the stale entries.
- ALU single write: alu_valid, alu_wa=5, alu_wd=0xDEADBEEF at edge N, after issue_wa=5 → wen=1, wa=5, wd=0xDEADBEEF in cycle N+1; pending[5] 1→0 after that cycle.
- Load latency / order: loads to x1, x2, x3 (0x11, 0x22, 0x33) on consecutive cycles with alu idle → writes appear in order x1, x2, x3, first write 2 cycles after the first push.
- ALU priority and full FIFO: fill FIFO with 4 loads while alu_valid is held high → alu_ready=1 and ALU writes win until count=4; then alu_ready=0 and ld_ready=0 while the FIFO drains one head entry.
- x0 suppression: alu_wa=0, alu_wd=0xFFFFFFFF → alu_ready=1, wen stays 0; issue_wa=0 leaves pending=0.
- Set/clear collision: issue_valid, issue_wa=7 on the same edge that retires a write to x7 → pending[7]=1 afterwards; the next write to x7 clears it.
